// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, req/ack fetch from instruction memory, and a small
// {pc, word} buffer feeding the IR. `IFU_PREFETCH_EN` selects a 2-entry buffer (else 1).
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              directives_coming,
    output logic [15:0]       output_directives,
    input  logic              ir_ready,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

`ifdef IFU_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ENT_W  = ADDR_W + WORD_W;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        STALL   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              mem_req_n;
    logic [ADDR_W-1:0] mem_addr_n;

    logic              ack_ok, push, pop, slot_free;
    logic [ENT_W-1:0]  head, head_n;
    logic              head_v, head_v_n;
    logic [CNT_W-1:0]  count_n;
`ifdef IFU_PREFETCH_EN
    logic [ENT_W-1:0]  tail, tail_n;
    logic              tail_v, tail_v_n;
`endif

    // An ack only counts against a live request; a stale ack after reset is ignored.
    assign ack_ok = mem_req & mem_ack;
    assign push   = ack_ok & (state == FETCH) & ~redirect;
    assign pop    = head_v & ir_ready;

    assign directives_coming = head_v;
    assign output_directives = head[WORD_W-1:0];
    assign pc_out            = head[ENT_W-1:WORD_W];

    // Buffer next-state: pop first, then push into the first free slot; redirect flushes.
    always_comb begin
        head_n   = head;
        head_v_n = head_v;
`ifdef IFU_PREFETCH_EN
        tail_n   = tail;
        tail_v_n = tail_v;
        if (pop) begin
            head_n   = tail;
            head_v_n = tail_v;
            tail_v_n = 1'b0;
        end
        if (push) begin
            if (!head_v_n) begin
                head_n   = {pc, mem_rdata};
                head_v_n = 1'b1;
            end else begin
                tail_n   = {pc, mem_rdata};
                tail_v_n = 1'b1;
            end
        end
        if (redirect) begin
            head_v_n = 1'b0;
            tail_v_n = 1'b0;
        end
        count_n = CNT_W'(head_v_n) + CNT_W'(tail_v_n);
`else
        if (pop) begin
            head_v_n = 1'b0;
        end
        if (push) begin
            head_n   = {pc, mem_rdata};
            head_v_n = 1'b1;
        end
        if (redirect) begin
            head_v_n = 1'b0;
        end
        count_n = CNT_W'(head_v_n);
`endif
        slot_free = (count_n < CNT_W'(DEPTH));
    end

    // Fetch FSM next-state; mem_addr is frozen only while discarding an orphaned request.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        unique case (state)
            FETCH: begin
                if (ack_ok) begin
                    if (redirect) begin
                        pc_n    = redirect_pc;
                        state_n = halt ? STALL : FETCH;
                    end else begin
                        pc_n    = pc + ADDR_W'(1);
                        state_n = (slot_free && !halt) ? FETCH : STALL;
                    end
                end else if (redirect) begin
                    pc_n    = redirect_pc;
                    state_n = mem_req ? DISCARD : (halt ? STALL : FETCH);
                end else if (!mem_req && halt) begin
                    state_n = STALL;
                end
            end
            STALL: begin
                if (redirect) begin
                    pc_n = redirect_pc;
                end
                if (slot_free && !halt) begin
                    state_n = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_n = redirect_pc;
                end
                if (ack_ok) begin
                    state_n = halt ? STALL : FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
        mem_req_n  = (state_n != STALL);
        mem_addr_n = (state_n == DISCARD) ? mem_addr : pc_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            head     <= {RESET_PC, 16'h0000};
            head_v   <= 1'b0;
`ifdef IFU_PREFETCH_EN
            tail     <= '0;
            tail_v   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            mem_req  <= mem_req_n;
            mem_addr <= mem_addr_n;
            head     <= head_n;
            head_v   <= head_v_n;
`ifdef IFU_PREFETCH_EN
            tail     <= tail_n;
            tail_v   <= tail_v_n;
`endif
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit that drives the instruction register. It holds the program counter and fetches 16-bit instruction words from instruction memory over a req/ack handshake. It buffers the words and presents them to the IR register on the `directives_coming` / `input_directives` interface, with a ready back-pressure signal. A jump or branch redirect flushes the buffer and discards any word still in flight.

## Interface
- `ADDR_W`, 8, PC / instruction-memory address width; matches the 8-bit instruction address field.
- `RESET_PC`, 8'h00, PC value loaded on reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `mem_req`  out  1  fetch request; held high until `mem_ack`.
- `mem_addr`  out  ADDR_W  fetch address; stable while `mem_req` is high.
- `mem_ack`  in  1  one-cycle acknowledge; `mem_rdata` is valid in this cycle.
- `mem_rdata`  in  16  instruction word.
- `directives_coming`  out  1  buffer head is valid; drives the IR `directives_coming` input.
- `output_directives`  out  16  buffer head word; drives IR `input_directives`. Field layout: op [15:12], I11..I8 [11:8], address [7:0].
- `ir_ready`  in  1  IR accepts the word this cycle.
- `pc_out`  out  ADDR_W  address of the word currently presented.
- `redirect`  in  1  jump/branch taken this cycle.
- `redirect_pc`  in  ADDR_W  new PC; sampled only when `redirect`=1.
- `halt`  in  1  blocks new requests while high.

## Operation
- The FIFO holds `{pc, word}` entries. Depth is DEPTH: 2, or 1 (see Configuration).
- The head of the FIFO drives `output_directives` and `pc_out`.
- A transfer occurs when `directives_coming && ir_ready`; the head is popped on that edge.
- The FSM has three states:
  - FETCH: `mem_req`=1 with `mem_addr`=PC. On `mem_ack`, `{PC, mem_rdata}` is pushed and PC is incremented. The next state is FETCH if free slots remain after this cycle's push/pop and `halt`=0; otherwise STALL.
  - STALL: `mem_req`=0. Go to FETCH when the post-pop count is below DEPTH and `halt`=0.
  - DISCARD: `mem_req`=1 with `mem_addr` held at the old address. On `mem_ack`, the data is dropped and the FSM goes to FETCH, or to STALL if `halt`=1.
- Handshake rules:
  - A request is never withdrawn before its ack.
  - `mem_addr` must not change while `mem_req`=1 and no ack has been received.
  - `mem_req` may stay high across back-to-back fetches; `mem_addr` changes only on the edge following an ack.
- Redirect behaviour (highest priority):
  - On the edge, the FIFO is flushed and PC ← `redirect_pc`.
  - A handshake that completes in the same cycle counts as accepted by the IR.
  - If in FETCH with no ack this cycle: go to DISCARD, then fetch from `redirect_pc`.
  - If an ack arrives in the redirect cycle: the data is dropped and the FSM goes to FETCH at `redirect_pc`.
  - If in DISCARD: stay there; the later PC is kept.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF increments to 8'h00.
- `halt` only blocks new requests. An outstanding request completes normally and the FIFO keeps draining.
- A push at full cannot occur, because a request is only issued when a slot is free.

## Timing
- Reset values (asynchronous):
  - `mem_req`=0, `mem_addr`=RESET_PC.
  - `directives_coming`=0, `output_directives`=16'h0000, `pc_out`=RESET_PC.
  - FIFO empty, state FETCH.
- First request: `mem_req` rises in the first clock cycle after `rst` falls.
- Latency: an ack in cycle N gives `directives_coming`=1 in cycle N+1. All outputs are registered; there is no combinational path from `mem_rdata` to the outputs.
- Throughput: with a zero-wait memory (ack in the cycle after req), DEPTH=2, and `ir_ready`=1 held, one word is delivered per 2 cycles.
- `rst` asserted mid-fetch: state is cleared immediately. The pending ack is ignored, because state is FETCH with a fresh request.

## Configuration
- `IFU_PREFETCH_EN` defined: DEPTH=2. The next word is fetched while the current one waits on `ir_ready`.
- `IFU_PREFETCH_EN` undefined: DEPTH=1. No request is issued while the word is unconsumed. The next request starts on the edge after the IR handshake.

## Test plan
- Reset release, zero-wait memory returning word = 16'h1000+addr, `ir_ready`=1:
  - The IR sees 16'h1000, 16'h1001, 16'h1002 in order, with `pc_out` 0, 1, 2.
- `ir_ready`=0 for 10 cycles:
  - With prefetch: exactly 2 requests complete, then `mem_req`=0.
  - Without prefetch: exactly 1 request completes, then `mem_req`=0.
  - When `ir_ready` returns, both buffered words are delivered in order.
- `redirect` with `redirect_pc`=8'h40 while a 3-cycle-latency fetch of 8'h05 is pending:
  - `mem_addr` stays 8'h05 until the ack and that word never reaches the IR.
  - The next request is to 8'h40.
- `RESET_PC`=8'hFE:
  - Fetched addresses are FE, FF, 00, 01.
- `halt`=1 with a request outstanding:
  - The word is delivered and no further `mem_req` is issued.
  - Fetching resumes from the next PC after `halt`=0.
- `rst` pulsed mid-wait:
  - All outputs return to reset values in the same cycle.
  - The stale ack produces no word.
